adc_frame_packer: RTL

Downstream stage of the per-chain ADC SPI capture logic.
- Consumes one daisy-chain byte stream: write strobe, 8-bit data, frame-end flag.
- Packs bytes little-endian into 32-bit words and appends a trailer word per frame (frame counter + byte count).
- Delivers words on a valid/ready stream through a small output FIFO, so the external read side (DMA/packetiser) can stall without back-pressuring the SPI capture.

---
 rtl/adc_frame_packer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_packer.sv
// ADC frame packer: packs a daisy-chain byte stream into 32-bit words
// with a per-frame trailer, delivered through a small FWFT output FIFO.
module adc_frame_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             adc_to_fifo_wen_hp,
  input  logic [7:0]       adc_to_fifo_wdata,
  input  logic             adc_frame_flag_h,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_last,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 37;

  logic [31:0]      acc_q, acc_d;
  logic [3:0]       keep_q, keep_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic [3:0]       hold_keep_q, hold_keep_d;
  logic             hold_v_q, hold_v_d;
  logic [31:0]      trl_q, trl_d;
  logic             trl_v_q, trl_v_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             strobe;
  logic             fend;
  logic             wdone;
  logic [31:0]      new_acc;
  logic [3:0]       new_keep;
  logic [CNT_W-1:0] byte_cnt_inc;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             can_push;
  logic             do_push;
  logic             drop;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head;

  // Byte accumulation, word completion and trailer capture
  always_comb begin
    strobe       = adc_to_fifo_wen_hp;
    fend         = strobe & adc_frame_flag_h;
    wdone        = strobe & ((idx_q == 2'd3) | adc_frame_flag_h);
    new_acc      = acc_q | ({24'h0, adc_to_fifo_wdata} << {idx_q, 3'b000});
    new_keep     = keep_q | (4'b0001 << idx_q);
    byte_cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;
    acc_d        = acc_q;
    keep_d       = keep_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    trl_d        = trl_q;
    if (strobe) begin
      byte_cnt_d = byte_cnt_inc;
      if (wdone) begin
        hold_data_d = new_acc;
        hold_keep_d = new_keep;
        acc_d       = '0;
        keep_d      = '0;
        idx_d       = '0;
      end else begin
        acc_d  = new_acc;
        keep_d = new_keep;
        idx_d  = idx_q + 2'd1;
      end
      if (fend) begin
        trl_d       = {16'(frame_cnt_q), 16'(byte_cnt_inc)};
        frame_cnt_d = frame_cnt_q + 1'b1;
        byte_cnt_d  = '0;
      end
    end
  end

  // Push arbiter: pending data word ahead of pending trailer
  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
               (wptr_q[AW] != rptr_q[AW]);
    pop      = !empty && m_ready;
    push_req = hold_v_q | trl_v_q;
    can_push = !full || pop;
    do_push  = push_req && can_push;
    drop     = push_req && !can_push;
    if (hold_v_q) begin
      push_entry = {1'b0, hold_keep_q, hold_data_q};
    end else begin
      push_entry = {1'b1, 4'hF, trl_q};
    end
    hold_v_d = wdone;
    trl_v_d  = trl_v_q && hold_v_q;
    if (fend) begin
      trl_v_d = 1'b1;
    end
  end

  // Output FIFO pointers, storage and overflow bookkeeping
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_entry;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (!(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // Head of FIFO drives the stream; zero while empty
  always_comb begin
    head    = mem_q[rptr_q[AW-1:0]];
    m_valid = !empty;
    if (empty) begin
      m_data = '0;
      m_keep = '0;
      m_last = 1'b0;
    end else begin
      m_data = head[31:0];
      m_keep = head[35:32];
      m_last = head[36];
    end
    ovf      = ovf_q;
    drop_cnt = drop_cnt_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_q       <= '0;
      keep_q      <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      hold_v_q    <= 1'b0;
      trl_q       <= '0;
      trl_v_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_v_q    <= hold_v_d;
      trl_q       <= trl_d;
      trl_v_q     <= trl_v_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      mem_q       <= mem_d;
    end
  end

endmodule
